// File: rtl/id_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// id_stage_pipe_if
//   Bundle of every non-clock signal of the decode stage.
//   slave  : the decode stage itself (id_stage_pipe).
//   master : the surrounding pipeline (IF, register file, EX/MEM, EX input).
//
//   IF side     : in_valid, IR_in, PC_in -> stage ; stall_out <- stage
//   Reg file    : rd1_addr/rd2_addr <- stage ; rd1_data/rd2_data -> stage
//   Bypass taps : ex_wr_valid, ex_is_load, ex_wr_addr, ex_wr_data,
//                 mem_wr_valid, mem_wr_addr, mem_wr_data -> stage
//   EX side     : out_valid, IR_out, PC_out, X, Y, dest_addr, dest_we,
//                 halted <- stage ; stall_in, flush -> stage
//
// Handshake: an instruction transfers from IF into decode on a posedge
// where in_valid=1 and stall_out=0; while stall_out=1 IF must hold
// in_valid/IR_in/PC_in unchanged. The output register transfers to EX on a
// posedge where out_valid=1 and stall_in=0; while stall_in=1 the output
// register is frozen (flush excepted).
// ---------------------------------------------------------------------------
interface id_stage_pipe_if #(
    parameter int WIDTH        = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int PC_W         = WIDTH - 2
);
    logic                    in_valid;
    logic [WIDTH-1:0]        IR_in;
    logic [PC_W-1:0]         PC_in;
    logic                    stall_in;
    logic                    flush;
    logic [REG_ADDR_LEN-1:0] rd1_addr;
    logic [WIDTH-1:0]        rd1_data;
    logic [REG_ADDR_LEN-1:0] rd2_addr;
    logic [WIDTH-1:0]        rd2_data;
    logic                    ex_wr_valid;
    logic                    ex_is_load;
    logic [REG_ADDR_LEN-1:0] ex_wr_addr;
    logic [WIDTH-1:0]        ex_wr_data;
    logic                    mem_wr_valid;
    logic [REG_ADDR_LEN-1:0] mem_wr_addr;
    logic [WIDTH-1:0]        mem_wr_data;
    logic                    stall_out;
    logic                    out_valid;
    logic [WIDTH-1:0]        IR_out;
    logic [PC_W-1:0]         PC_out;
    logic [WIDTH-1:0]        X;
    logic [WIDTH-1:0]        Y;
    logic [REG_ADDR_LEN-1:0] dest_addr;
    logic                    dest_we;
    logic                    halted;

    modport master (
        output in_valid, IR_in, PC_in, stall_in, flush,
        output rd1_data, rd2_data,
        output ex_wr_valid, ex_is_load, ex_wr_addr, ex_wr_data,
        output mem_wr_valid, mem_wr_addr, mem_wr_data,
        input  rd1_addr, rd2_addr, stall_out,
        input  out_valid, IR_out, PC_out, X, Y, dest_addr, dest_we, halted
    );

    modport slave (
        input  in_valid, IR_in, PC_in, stall_in, flush,
        input  rd1_data, rd2_data,
        input  ex_wr_valid, ex_is_load, ex_wr_addr, ex_wr_data,
        input  mem_wr_valid, mem_wr_addr, mem_wr_data,
        output rd1_addr, rd2_addr, stall_out,
        output out_valid, IR_out, PC_out, X, Y, dest_addr, dest_we, halted
    );
endinterface

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
//   Registered instruction-decode stage of the MyProc2 pipeline (IF -> ID ->
//   EX). Decodes IR_in, drives the two register-file read ports, resolves
//   operands X/Y, detects RAW hazards against the EX and MEM write-backs,
//   stalls IF and inserts bubbles, and hands X/Y/IR/PC to EX through one
//   clocked output register.
//
// Ports:
//   clk   - clock, all state updates on posedge
//   rst_n - asynchronous active-low reset
//   bus   - id_stage_pipe_if.slave, all pipeline signals (see interface)
//
// Configuration:
//   ID_FORWARD_EN - when defined, EX (non-load) and MEM results are bypassed
//                   into X/Y; only an EX load match stalls. When undefined,
//                   any EX/MEM match stalls and no bypass muxes exist.
//
// Instruction format: OpCode[31:26] Rd[25:21] Rs[20:16] Rt[15:11]
// Imm[15:0] Tgt[25:0]. Opcode values below follow the ISA.v classes;
// the NOP instruction word is all zeros.
// ---------------------------------------------------------------------------
module id_stage_pipe #(
    parameter int WIDTH        = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int PC_W         = WIDTH - 2
) (
    input  logic           clk,
    input  logic           rst_n,
    id_stage_pipe_if.slave bus
);

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_R    = 6'h01;
    localparam logic [5:0] OP_I    = 6'h02;
    localparam logic [5:0] OP_LW   = 6'h03;
    localparam logic [5:0] OP_LH   = 6'h04;
    localparam logic [5:0] OP_LD   = 6'h05;
    localparam logic [5:0] OP_SW   = 6'h06;
    localparam logic [5:0] OP_SH   = 6'h07;
    localparam logic [5:0] OP_SD   = 6'h08;
    localparam logic [5:0] OP_BR   = 6'h09;
    localparam logic [5:0] OP_J    = 6'h0A;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [WIDTH-1:0] NOP_IR = {OP_NOP, {(WIDTH-6){1'b0}}};

    // Output register
    logic                    r_out_valid;
    logic [WIDTH-1:0]        r_ir_out;
    logic [PC_W-1:0]         r_pc_out;
    logic [WIDTH-1:0]        r_x;
    logic [WIDTH-1:0]        r_y;
    logic [REG_ADDR_LEN-1:0] r_dest_addr;
    logic                    r_dest_we;
    logic                    r_halted;

    // Field split
    logic [5:0]              w_op;
    logic [REG_ADDR_LEN-1:0] w_rd;
    logic [REG_ADDR_LEN-1:0] w_rs;
    logic [REG_ADDR_LEN-1:0] w_rt;
    logic [15:0]             w_imm;
    logic [25:0]             w_tgt;

    assign w_op  = bus.IR_in[31:26];
    assign w_rd  = REG_ADDR_LEN'(bus.IR_in[25:21]);
    assign w_rs  = REG_ADDR_LEN'(bus.IR_in[20:16]);
    assign w_rt  = REG_ADDR_LEN'(bus.IR_in[15:11]);
    assign w_imm = bus.IR_in[15:0];
    assign w_tgt = bus.IR_in[25:0];

    // Opcode class decode
    logic                    w_use1;
    logic                    w_use2;
    logic [REG_ADDR_LEN-1:0] w_src1;
    logic [REG_ADDR_LEN-1:0] w_src2;
    logic                    w_writes;

    always_comb begin
        w_use1   = 1'b0;
        w_use2   = 1'b0;
        w_src1   = '0;
        w_src2   = '0;
        w_writes = 1'b0;
        case (w_op)
            OP_R: begin
                w_use1   = 1'b1;
                w_src1   = w_rs;
                w_use2   = 1'b1;
                w_src2   = w_rt;
                w_writes = 1'b1;
            end
            OP_I, OP_LW, OP_LH, OP_LD: begin
                w_use1   = 1'b1;
                w_src1   = w_rs;
                w_writes = 1'b1;
            end
            OP_BR: begin
                w_use1 = 1'b1;
                w_src1 = w_rd;
            end
            OP_SW, OP_SH, OP_SD: begin
                w_use1 = 1'b1;
                w_src1 = w_rd;
                w_use2 = 1'b1;
                w_src2 = w_rs;
            end
            default: begin
                // J_TYPE, NOP, HALT and unknown opcodes read nothing
            end
        endcase
    end

    // Unused ports carry address 0 because w_srcN defaults to 0
    assign bus.rd1_addr = w_src1;
    assign bus.rd2_addr = w_src2;

    // Producer matches; register 0 can never match because it is never written
    logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;

    assign w_ex_m1  = w_use1 && (w_src1 != '0) && bus.ex_wr_valid  && (bus.ex_wr_addr  == w_src1);
    assign w_ex_m2  = w_use2 && (w_src2 != '0) && bus.ex_wr_valid  && (bus.ex_wr_addr  == w_src2);
    assign w_mem_m1 = w_use1 && (w_src1 != '0) && bus.mem_wr_valid && (bus.mem_wr_addr == w_src1);
    assign w_mem_m2 = w_use2 && (w_src2 != '0) && bus.mem_wr_valid && (bus.mem_wr_addr == w_src2);

    logic             w_hazard;
    logic [WIDTH-1:0] w_val1;
    logic [WIDTH-1:0] w_val2;

`ifdef ID_FORWARD_EN
    // A load in EX has no data yet, so only that case has to wait.
    // EX is younger than MEM, so its value wins when both match.
    assign w_hazard = bus.in_valid && bus.ex_is_load && (w_ex_m1 || w_ex_m2);
    assign w_val1   = (w_src1 == '0) ? '0 :
                      w_ex_m1        ? bus.ex_wr_data :
                      w_mem_m1       ? bus.mem_wr_data : bus.rd1_data;
    assign w_val2   = (w_src2 == '0) ? '0 :
                      w_ex_m2        ? bus.ex_wr_data :
                      w_mem_m2       ? bus.mem_wr_data : bus.rd2_data;
`else
    assign w_hazard = bus.in_valid && (w_ex_m1 || w_ex_m2 || w_mem_m1 || w_mem_m2);
    assign w_val1   = (w_src1 == '0) ? '0 : bus.rd1_data;
    assign w_val2   = (w_src2 == '0) ? '0 : bus.rd2_data;
`endif

    logic [WIDTH-1:0]        w_x;
    logic [WIDTH-1:0]        w_y;
    logic [REG_ADDR_LEN-1:0] w_dest_addr;
    logic                    w_dest_we;

    assign w_x         = w_use1 ? w_val1 : WIDTH'(w_tgt);
    assign w_y         = w_use2 ? w_val2 : {{(WIDTH-16){w_imm[15]}}, w_imm};
    assign w_dest_addr = w_writes ? w_rd : '0;
    assign w_dest_we   = w_writes && (w_rd != '0);

    // A HALT sitting in the output register blocks decode immediately so
    // nothing younger slips in behind it before halted is set.
    logic w_out_is_halt;
    assign w_out_is_halt = r_out_valid && (r_ir_out[31:26] == OP_HALT);

    assign bus.stall_out = r_halted || w_out_is_halt ||
                           (!bus.flush && (bus.stall_in || w_hazard));

    // w_load: output register updates this edge. w_take: it takes the
    // decoded instruction rather than a bubble. Once halted, the register
    // is forced to a bubble even under stall_in so out_valid stays low.
    logic w_load;
    logic w_take;

    assign w_load = bus.flush || r_halted || !bus.stall_in;
    assign w_take = !bus.flush && !r_halted && !bus.stall_in &&
                    !w_out_is_halt && !w_hazard && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_ir_out    <= NOP_IR;
            r_pc_out    <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_dest_addr <= '0;
            r_dest_we   <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_halted <= r_halted || w_out_is_halt;
            if (w_load) begin
                r_out_valid <= w_take;
                r_ir_out    <= w_take ? bus.IR_in : NOP_IR;
                r_pc_out    <= w_take ? bus.PC_in : '0;
                r_x         <= w_take ? w_x : '0;
                r_y         <= w_take ? w_y : '0;
                r_dest_addr <= w_take ? w_dest_addr : '0;
                r_dest_we   <= w_take && w_dest_we;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.IR_out    = r_ir_out;
    assign bus.PC_out    = r_pc_out;
    assign bus.X         = r_x;
    assign bus.Y         = r_y;
    assign bus.dest_addr = r_dest_addr;
    assign bus.dest_we   = r_dest_we;
    assign bus.halted    = r_halted;

endmodule

// File: tb/tb_id_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_stage_pipe
//   Bench for id_stage_pipe. A reference model of the decode stage, written
//   from the opcode-class rules, is advanced once per cycle and compared
//   against every DUT output on each falling edge. Directed sequences with
//   literal expectations run first, then randomized segments.
//   Build with +define+ID_FORWARD_EN to check the forwarding variant.
// ---------------------------------------------------------------------------
module tb_id_stage_pipe;

    localparam int WIDTH = 32;
    localparam int RAL   = 5;
    localparam int PC_W  = WIDTH - 2;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_R    = 6'h01;
    localparam logic [5:0] OP_I    = 6'h02;
    localparam logic [5:0] OP_LW   = 6'h03;
    localparam logic [5:0] OP_LH   = 6'h04;
    localparam logic [5:0] OP_LD   = 6'h05;
    localparam logic [5:0] OP_SW   = 6'h06;
    localparam logic [5:0] OP_SH   = 6'h07;
    localparam logic [5:0] OP_SD   = 6'h08;
    localparam logic [5:0] OP_BR   = 6'h09;
    localparam logic [5:0] OP_J    = 6'h0A;
    localparam logic [5:0] OP_HALT = 6'h3F;
    localparam logic [31:0] NOP_IR = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.WIDTH(WIDTH), .REG_ADDR_LEN(RAL), .PC_W(PC_W)) bus();

    id_stage_pipe #(.WIDTH(WIDTH), .REG_ADDR_LEN(RAL), .PC_W(PC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register file seen by the stage; entry 0 holds junk on purpose
    logic [31:0] regs [0:31];
    assign bus.rd1_data = regs[bus.rd1_addr];
    assign bus.rd2_data = regs[bus.rd2_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Opcode class: 0 none, 1 R, 2 I/loads, 3 branch, 4 stores
    function automatic int cls_of(input logic [5:0] op);
        if (op == OP_R) return 1;
        if (op == OP_I || op == OP_LW || op == OP_LH || op == OP_LD) return 2;
        if (op == OP_BR) return 3;
        if (op == OP_SW || op == OP_SH || op == OP_SD) return 4;
        return 0;
    endfunction

    task automatic m_decode(input logic [31:0] ir, output bit u1, output bit u2,
                            output bit wr, output logic [4:0] s1, output logic [4:0] s2);
        int c;
        c  = cls_of(ir[31:26]);
        u1 = (c != 0);
        u2 = (c == 1) || (c == 4);
        wr = (c == 1) || (c == 2);
        s1 = (c == 1 || c == 2) ? ir[20:16] : (c == 3 || c == 4) ? ir[25:21] : 5'd0;
        s2 = (c == 1) ? ir[15:11] : (c == 4) ? ir[20:16] : 5'd0;
    endtask

    function automatic bit ex_hit(input logic [4:0] s);
        return s != 0 && bus.ex_wr_valid && bus.ex_wr_addr == s;
    endfunction
    function automatic bit mem_hit(input logic [4:0] s);
        return s != 0 && bus.mem_wr_valid && bus.mem_wr_addr == s;
    endfunction

    function automatic bit src_blocks(input logic [4:0] s);
`ifdef ID_FORWARD_EN
        return ex_hit(s) && bus.ex_is_load;
`else
        return ex_hit(s) || mem_hit(s);
`endif
    endfunction

    function automatic logic [31:0] src_value(input logic [4:0] s);
        if (s == 0) return 32'd0;
`ifdef ID_FORWARD_EN
        if (ex_hit(s)) return bus.ex_wr_data;
        if (mem_hit(s)) return bus.mem_wr_data;
`endif
        return regs[s];
    endfunction

    logic        m_valid, m_dwe, m_halted;
    logic [31:0] m_ir, m_x, m_y;
    logic [29:0] m_pc;
    logic [4:0]  m_daddr;

    task automatic m_bubble();
        m_valid = 0; m_ir = NOP_IR; m_pc = '0; m_x = '0; m_y = '0; m_daddr = '0; m_dwe = 0;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin : cmp
        bit u1, u2, wr, haz, halt_out;
        logic [4:0] s1, s2;
        logic [31:0] ir;
        if (!rst_n) begin
            m_bubble();
            m_halted = 0;
        end
        chk("out_valid", bus.out_valid, m_valid);
        chk("IR_out", bus.IR_out, m_ir);
        chk("PC_out", bus.PC_out, m_pc);
        chk("X", bus.X, m_x);
        chk("Y", bus.Y, m_y);
        chk("dest_we", bus.dest_we, m_dwe);
        chk("halted", bus.halted, m_halted);
        if (m_valid) chk("dest_addr", bus.dest_addr, m_daddr);

        ir = bus.IR_in;
        m_decode(ir, u1, u2, wr, s1, s2);
        chk("rd1_addr", bus.rd1_addr, s1);
        chk("rd2_addr", bus.rd2_addr, s2);
        haz      = bus.in_valid && ((u1 && src_blocks(s1)) || (u2 && src_blocks(s2)));
        halt_out = m_valid && m_ir[31:26] == OP_HALT;
        chk("stall_out", bus.stall_out,
            m_halted || halt_out || (!bus.flush && (bus.stall_in || haz)));

        if (rst_n) begin
            if (bus.flush || m_halted) m_bubble();
            else if (bus.stall_in) begin
                // EX not accepting: output register frozen
            end else if (halt_out || haz || !bus.in_valid) m_bubble();
            else begin
                m_valid = 1;
                m_ir    = ir;
                m_pc    = bus.PC_in;
                m_x     = u1 ? src_value(s1) : {6'd0, ir[25:0]};
                m_y     = u2 ? src_value(s2) : {{16{ir[15]}}, ir[15:0]};
                m_daddr = wr ? ir[25:21] : 5'd0;
                m_dwe   = wr && ir[25:21] != 0;
            end
            m_halted = m_halted || halt_out;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.IR_in = NOP_IR; bus.PC_in = '0;
        bus.stall_in = 0; bus.flush = 0;
        bus.ex_wr_valid = 0; bus.ex_is_load = 0; bus.ex_wr_addr = '0; bus.ex_wr_data = '0;
        bus.mem_wr_valid = 0; bus.mem_wr_addr = '0; bus.mem_wr_data = '0;
    endtask

    task automatic drive_instr(input logic [31:0] ir, input logic [29:0] pc);
        bus.in_valid = 1; bus.IR_in = ir; bus.PC_in = pc;
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rd, rs, rt);
        return {OP_R, rd, rs, rt, 11'd0};
    endfunction
    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rd, rs,
                                         input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    logic [5:0] op_pool [12];
    bit held;

    task automatic rand_cycle(input bit allow_halt);
        logic [5:0] op;
        if (!held) begin
            op = op_pool[$urandom_range(0, 11)];
            if (allow_halt && $urandom_range(0, 149) == 0) op = OP_HALT;
            bus.in_valid = ($urandom_range(0, 9) < 8);
            bus.IR_in    = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 11'($urandom)};
            bus.PC_in    = 30'($urandom);
        end
        bus.stall_in     = ($urandom_range(0, 6) == 0);
        bus.flush        = ($urandom_range(0, 19) == 0);
        bus.ex_wr_valid  = $urandom_range(0, 1);
        bus.ex_is_load   = ($urandom_range(0, 9) < 3);
        bus.ex_wr_addr   = 5'($urandom_range(0, 7));
        bus.ex_wr_data   = $urandom;
        bus.mem_wr_valid = $urandom_range(0, 1);
        bus.mem_wr_addr  = 5'($urandom_range(0, 7));
        bus.mem_wr_data  = $urandom;
        if ($urandom_range(0, 4) == 0) regs[$urandom_range(1, 7)] = $urandom;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hDEAD_BEEF;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        op_pool = '{OP_NOP, OP_R, OP_I, OP_LW, OP_LH, OP_LD,
                    OP_SW, OP_SH, OP_SD, OP_BR, OP_J, 6'h2A};
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst IR_out", bus.IR_out, NOP_IR);
        chk("rst PC_out", bus.PC_out, 0);
        chk("rst X", bus.X, 0);
        chk("rst Y", bus.Y, 0);
        chk("rst dest_addr", bus.dest_addr, 0);
        chk("rst dest_we", bus.dest_we, 0);
        chk("rst halted", bus.halted, 0);
        rst_n = 1;

        // R_TYPE Rd=3 Rs=1 Rt=2
        drive_instr(mk_r(5'd3, 5'd1, 5'd2), 30'h100);
        #1;
        chk("r stall_out", bus.stall_out, 0);
        chk("r rd1_addr", bus.rd1_addr, 1);
        chk("r rd2_addr", bus.rd2_addr, 2);
        tick();
        chk("r X", bus.X, 32'd5);
        chk("r Y", bus.Y, 32'd7);
        chk("r dest_addr", bus.dest_addr, 3);
        chk("r dest_we", bus.dest_we, 1);
        chk("r out_valid", bus.out_valid, 1);
        chk("r PC_out", bus.PC_out, 30'h100);

        // LW with negative immediate
        drive_instr(mk_i(OP_LW, 5'd4, 5'd1, 16'hFFF0), 30'h101);
        tick();
        chk("lw Y", bus.Y, 32'hFFFF_FFF0);
        chk("lw X", bus.X, 32'd5);
        chk("lw dest_addr", bus.dest_addr, 4);

        // Dependent R_TYPE behind the load: one bubble, then issue
        drive_instr(mk_r(5'd5, 5'd4, 5'd0), 30'h102);
        bus.ex_wr_valid = 1; bus.ex_wr_addr = 5'd4; bus.ex_is_load = 1; bus.ex_wr_data = 32'h77;
        #1;
        chk("ld-use stall_out", bus.stall_out, 1);
        tick();
        chk("ld-use bubble valid", bus.out_valid, 0);
        chk("ld-use bubble IR", bus.IR_out, NOP_IR);
        bus.ex_wr_valid = 0; bus.ex_is_load = 0;
        regs[4] = 32'd11;
        #1;
        chk("ld-use release", bus.stall_out, 0);
        tick();
        chk("ld-use issue valid", bus.out_valid, 1);
        chk("ld-use issue X", bus.X, 32'd11);
        chk("ld-use rt0 Y", bus.Y, 32'd0);

        // EX and MEM both target the source
        drive_instr(mk_r(5'd6, 5'd2, 5'd0), 30'h103);
        bus.ex_wr_valid = 1; bus.ex_wr_addr = 5'd2; bus.ex_wr_data = 32'd9; bus.ex_is_load = 0;
        bus.mem_wr_valid = 1; bus.mem_wr_addr = 5'd2; bus.mem_wr_data = 32'd1;
        #1;
`ifdef ID_FORWARD_EN
        chk("fwd stall_out", bus.stall_out, 0);
        tick();
        chk("fwd X", bus.X, 32'd9);
`else
        chk("nofwd stall_out", bus.stall_out, 1);
        tick();
        chk("nofwd bubble", bus.out_valid, 0);
`endif
        bus.ex_wr_valid = 0; bus.mem_wr_valid = 0;
        tick();

        // flush beats stall_in on a valid store
        drive_instr(mk_i(OP_SW, 5'd1, 5'd2, 16'h0010), 30'h104);
        bus.flush = 1; bus.stall_in = 1;
        #1;
        chk("flush stall_out", bus.stall_out, 0);
        tick();
        chk("flush out_valid", bus.out_valid, 0);
        chk("flush IR_out", bus.IR_out, NOP_IR);
        bus.flush = 0; bus.stall_in = 0;

        // HALT
        drive_instr({OP_HALT, 26'd0}, 30'h105);
        tick();
        chk("halt in output", bus.IR_out, {OP_HALT, 26'd0});
        chk("halt not yet", bus.halted, 0);
        #1;
        chk("halt blocks", bus.stall_out, 1);
        drive_instr(mk_r(5'd3, 5'd1, 5'd2), 30'h106);
        tick();
        chk("halted set", bus.halted, 1);
        chk("halted no valid", bus.out_valid, 0);
        chk("halted stall_out", bus.stall_out, 1);
        tick();
        chk("halted still no valid", bus.out_valid, 0);

        // Reset during a stall with a valid instruction held
        rst_n = 0;
        tick();
        rst_n = 1;
        drive_instr(mk_r(5'd3, 5'd1, 5'd2), 30'h107);
        tick();
        bus.stall_in = 1;
        tick();
        chk("held valid", bus.out_valid, 1);
        rst_n = 0;
        #1;
        chk("async rst valid", bus.out_valid, 0);
        chk("async rst IR", bus.IR_out, NOP_IR);
        chk("async rst X", bus.X, 0);
        chk("async rst Y", bus.Y, 0);
        chk("async rst halted", bus.halted, 0);
        tick();
        idle_inputs();
        rst_n = 1;

        // Randomized segments, each starting from reset
        for (int seg = 0; seg < 10; seg++) begin
            rst_n = 0;
            idle_inputs();
            held = 0;
            tick();
            rst_n = 1;
            for (int c = 0; c < 300; c++) begin
                rand_cycle(c > 100);
                #1;
                held = bus.stall_out;
                tick();
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
